// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Writeback request bus plus register-file write port.
//                Requesters and the bench use the master modport; the arbiter uses slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) ();
   logic                 stall;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*AW-1:0]   req_rd;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 reg_write;
   logic [AW-1:0]        write_reg;
   logic [DW-1:0]        write_data;
   logic [2:0]           grant_id;
   logic [15:0]          conflict_cnt;

   modport master (
      output stall, req_valid, req_rd, req_data,
      input  req_ready, reg_write, write_reg, write_data, grant_id, conflict_cnt
   );

   modport slave (
      input  stall, req_valid, req_rd, req_data,
      output req_ready, reg_write, write_reg, write_data, grant_id, conflict_cnt
   );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Arbitrates NREQ writeback requesters onto one register-file
//                write port. Define RR_ARB_EN for round-robin, else fixed priority.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  wire logic           clk,
   input  wire logic           rst,
   regfile_wb_arbiter_if.slave bus
);
   // Bus instance parameters must match NREQ/AW/DW.
   localparam int c_PW = $clog2(NREQ);

   logic [NREQ-1:0] w_grant;
   logic [c_PW-1:0] w_win;
   logic            w_any;
   logic            w_xfer;
   logic            w_conflict;
   logic [AW-1:0]   w_rd;
   logic [DW-1:0]   w_data;
   logic [AW-1:0]   w_rd_arr   [NREQ];
   logic [DW-1:0]   w_data_arr [NREQ];

   logic            we_q,    we_d;
   logic [AW-1:0]   wreg_q,  wreg_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [2:0]      gid_q,   gid_d;
   logic [15:0]     cnt_q,   cnt_d;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_rd_arr[gi]   = bus.req_rd[gi*AW +: AW];
         assign w_data_arr[gi] = bus.req_data[gi*DW +: DW];
      end
   endgenerate

`ifdef RR_ARB_EN
   logic [c_PW-1:0] ptr_q, ptr_d;

   // Search begins just after the last winner so every requester gets a turn.
   always_comb begin
      int idx;
      idx     = 0;
      w_grant = '0;
      w_win   = '0;
      w_any   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!w_any && bus.req_valid[c_PW'(idx)]) begin
            w_any                 = 1'b1;
            w_win                 = c_PW'(idx);
            w_grant[c_PW'(idx)]   = 1'b1;
         end
      end
   end

   assign ptr_d = w_xfer ? w_win : ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= c_PW'(NREQ - 1);
      else     ptr_q <= ptr_d;
   end
`else
   always_comb begin
      w_grant = '0;
      w_win   = '0;
      w_any   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_any && bus.req_valid[c_PW'(i)]) begin
            w_any               = 1'b1;
            w_win               = c_PW'(i);
            w_grant[c_PW'(i)]   = 1'b1;
         end
      end
   end
`endif

   assign w_xfer     = w_any & ~bus.stall;
   assign w_conflict = ($countones(bus.req_valid) >= 2) && !bus.stall;
   assign w_rd       = w_rd_arr[w_win];
   assign w_data     = w_data_arr[w_win];

   always_comb begin
      we_d    = 1'b0;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      gid_d   = gid_q;
      cnt_d   = cnt_q;
      if (w_xfer) begin
         we_d    = (w_rd != '0);
         wreg_d  = w_rd;
         wdata_d = w_data;
         gid_d   = 3'(w_win);
      end
      if (w_conflict && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
         gid_q   <= '0;
         cnt_q   <= '0;
      end else begin
         we_q    <= we_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         gid_q   <= gid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.req_ready    = (bus.stall || rst) ? '0 : w_grant;
   assign bus.reg_write    = we_q;
   assign bus.write_reg    = wreg_q;
   assign bus.write_data   = wdata_q;
   assign bus.grant_id     = gid_q;
   assign bus.conflict_cnt = cnt_q;
endmodule
`default_nettype wire
